bcd_time_counter: RTL
=====================

// Module: bcd_time_counter
// PURPOSE
// - Timekeeping stage directly upstream of the VGA clock renderer: holds HH:MM:SS as BCD digits.
// - Advances once per second from a clk prescaler and applies single-cycle adjust pulses from the button pulse generators.
// - Drives the digit and colour-offset inputs of the display stage.
// - Every digit is always in its legal range; no transient out-of-range codes (e.g. 10) ever appear on the outputs.
// PARAMETERS
// - TICKS_PER_SEC  25_000_000  clk cycles per second; prescaler counts 0..TICKS_PER_SEC-1; must be >= 2
// - CNT_W          $clog2(TICKS_PER_SEC)  prescaler width (derived, do not override)
// PORTS
// - clk            in   1  pixel clock; all state on rising edge
// - reset          in   1  asynchronous, active-high; clears all state
// - adj_sec_pulse  in   1  1-cycle pulse: seconds +1
// - adj_min_pulse  in   1  1-cycle pulse: minutes +1
// - adj_hrs_pulse  in   1  1-cycle pulse: hours +1
// - sec_u          out  4  seconds units 0..9
// - sec_d          out  3  seconds tens 0..5
// - min_u          out  4  minutes units 0..9
// - min_d          out  3  minutes tens 0..5
// - hrs_u          out  4  hours units 0..9 (0..3 when hrs_d==2)
// - hrs_d          out  2  hours tens 0..2
// - color_offset   out  4  increments on every minute advance, wraps 15->0
// - sec_tick       out  1  registered 1-cycle pulse, high on the cycle after the prescaler wraps
// BEHAVIOUR
// - Reset (async assert; deassert is synchronous to clk):
//   - all digits, color_offset, sec_tick and prescaler = 0
//   - displayed time 00:00:00
// - Prescaler: tick = (cnt == TICKS_PER_SEC-1).
//   - On tick, cnt <= 0; otherwise cnt <= cnt+1.
// - Advance terms, all evaluated combinationally from current registered state:
//   - inc_sec = tick | adj_sec_pulse
//   - inc_min = (tick & sec==59) | adj_min_pulse
//   - inc_hrs = (tick & sec==59 & min==59) | adj_hrs_pulse
// - Carry from a field into the next field comes only from tick.
//   - Adjust pulses wrap their own field and never carry: adj_sec at :59 -> :00, minutes unchanged.
// - Wrap rules:
//   - sec 59->00, min 59->00, hrs 23->00
//   - units roll 9->0 with tens +1
// - Simultaneous events:
//   - inc terms are ORed, so any field advances at most +1 per cycle.
//   - Example: tick at 12:34:59 with adj_min_pulse -> 12:35:00, not 12:36:00.
//   - Example: tick with adj_sec_pulse -> seconds +1 once.
// - color_offset <= color_offset + 1 (mod 16) on every cycle where inc_min is high, including adjust-driven advances.
// - Latency: digits and sec_tick update on the clk edge that samples tick or the pulse. Outputs are registered, with 1 cycle input->output.
// - Adjust pulses are assumed to be 1 cycle wide.
//   - A pulse held N cycles advances N times; no internal edge detection.
// - Reset mid-second: prescaler restarts from 0, so the first tick arrives TICKS_PER_SEC cycles after reset release.
// TESTING (TICKS_PER_SEC=4 unless stated)
// - Reset release -> 00:00:00, color_offset=0.
//   - sec_tick every 4th cycle, first one 4 cycles after release.
//   - sec_u=1 after the first tick.
// - Preload 23:59:58 via adjust pulses, run 2 ticks.
//   - Sequence must be 23:59:59 -> 00:00:00.
//   - color_offset +1; no digit ever out of range (checked every cycle).
// - Time 12:34:59, assert tick and adj_min_pulse in the same cycle -> 12:35:00, color_offset +1 only once.
// - adj_sec_pulse at 00:00:59 with no tick -> 00:00:00.
//   - adj_hrs_pulse at 23:xx -> 00:xx.
//   - adj_min at 00:59:xx -> 00:00:xx, hours unchanged.
// - 16 adj_min_pulse pulses from reset -> min=16, color_offset wraps to 0.
// - Assert reset mid-second (cnt=2) at 05:06:07.
//   - All outputs must be 0 immediately, without a clk edge.
//   - After release, the next tick must occur exactly 4 cycles later.

Source files
------------

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD timekeeper with a once-per-second prescaler and single-cycle adjust pulses.
// Only the prescaler tick carries between fields; adjust pulses wrap their own field.
module bcd_time_counter #(
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adj_sec_pulse,
    input  logic       adj_min_pulse,
    input  logic       adj_hrs_pulse,
    output logic [3:0] sec_u,
    output logic [2:0] sec_d,
    output logic [3:0] min_u,
    output logic [2:0] min_d,
    output logic [3:0] hrs_u,
    output logic [1:0] hrs_d,
    output logic [3:0] color_offset,
    output logic       sec_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sec_u_q, sec_u_d;
    logic [2:0]       sec_d_q, sec_d_d;
    logic [3:0]       min_u_q, min_u_d;
    logic [2:0]       min_d_q, min_d_d;
    logic [3:0]       hrs_u_q, hrs_u_d;
    logic [1:0]       hrs_d_q, hrs_d_d;
    logic [3:0]       color_q, color_d;
    logic             sec_tick_q, sec_tick_d;

    logic tick, sec_max, min_max;
    logic inc_sec, inc_min, inc_hrs;

    always_comb begin
        tick    = (cnt_q == CNT_W'(TICKS_PER_SEC - 1));
        sec_max = (sec_d_q == 3'd5) && (sec_u_q == 4'd9);
        min_max = (min_d_q == 3'd5) && (min_u_q == 4'd9);

        // Terms are ORed so a field advances at most once per cycle.
        inc_sec = tick | adj_sec_pulse;
        inc_min = (tick & sec_max) | adj_min_pulse;
        inc_hrs = (tick & sec_max & min_max) | adj_hrs_pulse;

        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        sec_tick_d = tick;
        color_d    = inc_min ? color_q + 4'd1 : color_q;

        sec_u_d = sec_u_q;
        sec_d_d = sec_d_q;
        if (inc_sec) begin
            if (sec_u_q == 4'd9) begin
                sec_u_d = '0;
                sec_d_d = (sec_d_q == 3'd5) ? '0 : sec_d_q + 3'd1;
            end else begin
                sec_u_d = sec_u_q + 4'd1;
            end
        end

        min_u_d = min_u_q;
        min_d_d = min_d_q;
        if (inc_min) begin
            if (min_u_q == 4'd9) begin
                min_u_d = '0;
                min_d_d = (min_d_q == 3'd5) ? '0 : min_d_q + 3'd1;
            end else begin
                min_u_d = min_u_q + 4'd1;
            end
        end

        hrs_u_d = hrs_u_q;
        hrs_d_d = hrs_d_q;
        if (inc_hrs) begin
            if ((hrs_d_q == 2'd2) && (hrs_u_q == 4'd3)) begin
                hrs_u_d = '0;
                hrs_d_d = '0;
            end else if (hrs_u_q == 4'd9) begin
                hrs_u_d = '0;
                hrs_d_d = hrs_d_q + 2'd1;
            end else begin
                hrs_u_d = hrs_u_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            sec_u_q    <= '0;
            sec_d_q    <= '0;
            min_u_q    <= '0;
            min_d_q    <= '0;
            hrs_u_q    <= '0;
            hrs_d_q    <= '0;
            color_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sec_u_q    <= sec_u_d;
            sec_d_q    <= sec_d_d;
            min_u_q    <= min_u_d;
            min_d_q    <= min_d_d;
            hrs_u_q    <= hrs_u_d;
            hrs_d_q    <= hrs_d_d;
            color_q    <= color_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign sec_u        = sec_u_q;
    assign sec_d        = sec_d_q;
    assign min_u        = min_u_q;
    assign min_d        = min_d_q;
    assign hrs_u        = hrs_u_q;
    assign hrs_d        = hrs_d_q;
    assign color_offset = color_q;
    assign sec_tick     = sec_tick_q;

endmodule
